// File: rtl/multicycle_pkg.sv
// Shared definitions for the multi-cycle RISC-V control unit.
// Latency: n/a (types, opcodes, select codes only).
// Backpressure: n/a.
//
// Contents: instruction opcodes, the 4-bit FSM state encoding, ALU operation
// codes and the datapath mux-select codes driven by multicycle_control.

package multicycle_pkg;

   // Opcodes recognised by the decoder
   localparam logic [6:0] OP_R    = 7'h33;
   localparam logic [6:0] OP_I    = 7'h13;
   localparam logic [6:0] OP_LUI  = 7'h37;
   localparam logic [6:0] OP_B    = 7'h63;
   localparam logic [6:0] OP_LW   = 7'h03;
   localparam logic [6:0] OP_SW   = 7'h23;
   localparam logic [6:0] OP_JAL  = 7'h6F;
   localparam logic [6:0] OP_JALR = 7'h67;

   // FSM state encoding; value 11 is unused and recovers to FETCH
   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_EXEC      = 4'd2,
      S_WB_ALU    = 4'd3,
      S_BRANCH    = 4'd4,
      S_ADDR      = 4'd5,
      S_MEM_RD    = 4'd6,
      S_WB_MEM    = 4'd7,
      S_MEM_WR    = 4'd8,
      S_JALR_ADDR = 4'd9,
      S_JUMP      = 4'd10,
      S_HALT      = 4'd12
   } state_t;

   // ALU operation codes
   localparam logic [2:0] ALU_R    = 3'b000;
   localparam logic [2:0] ALU_I    = 3'b001;
   localparam logic [2:0] ALU_U    = 3'b010;
   localparam logic [2:0] ALU_B    = 3'b011;
   localparam logic [2:0] ALU_ADD  = 3'b100;
   localparam logic [2:0] ALU_S    = 3'b101;
   localparam logic [2:0] ALU_J    = 3'b110;
   localparam logic [2:0] ALU_JALR = 3'b111;

   // PC source select
   localparam logic [1:0] PC_SRC_ALU    = 2'b00;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;

   // Register-file writeback source select
   localparam logic [1:0] WB_ALUOUT = 2'b00;
   localparam logic [1:0] WB_MDR    = 2'b01;
   localparam logic [1:0] WB_PC     = 2'b10;

   // ALU A operand select
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   // ALU B operand select
   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;

   // States that hold a memory access open until Mem_Ready_i
   function automatic logic is_mem_state(input state_t s);
      return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
   endfunction

endpackage

// File: rtl/multicycle_control_timer.sv
// Wait-cycle counter with timeout compare for the shared memory port.
// Latency: timeout is combinational from the registered count and ready.
// Backpressure: counts while active and ready is low; clears otherwise.
//
// Ports:
//   clk, reset  - clock and synchronous active-low reset
//   active      - FSM is in a memory-access state
//   ready       - memory handshake completed this cycle
//   timeout     - MEM_TIMEOUT wait cycles already spent and still no ready
//
// The count holds the number of wait cycles already spent in the current
// access. Once it equals MEM_TIMEOUT the access gets one more chance: ready in
// that cycle succeeds, otherwise timeout fires. CNT_W must be wide enough to
// hold MEM_TIMEOUT itself.

module mc_wait_timer
   import multicycle_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic active,
   input  logic ready,
   output logic timeout
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

   logic [CNT_W-1:0] cnt;

   assign timeout = active && !ready && (cnt == LIMIT);

   // Leaving a memory state always coincides with ready, timeout or the
   // state no longer being a memory state, so those three cover every
   // state change the count must be cleared on.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt <= '0;
      end else if (!active || ready || timeout) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + ONE;
      end
   end

endmodule

// File: rtl/multicycle_control.sv
// Control FSM sequencing the shared multi-cycle RISC-V datapath.
// Latency: 3-5 cycles per instruction plus one per memory wait cycle.
// Backpressure: FETCH/MEM_RD/MEM_WR stall on Mem_Ready_i; timeout -> HALT.
//
// Ports:
//   clk, reset        - clock and synchronous active-low reset
//   OP_i              - opcode field of the instruction register
//   Mem_Ready_i       - memory access completes this cycle
//   PC_Write_o, PC_Write_Cond_o, PC_Src_o, Old_PC_Write_o - PC update control
//   IorD_o, Mem_Read_o, Mem_Write_o, IR_Write_o            - memory port control
//   Reg_Write_o, Wb_Src_o                                   - writeback control
//   ALU_Src_A_o, ALU_Src_B_o, ALU_Op_o                      - ALU control
//   Retire_o          - one-cycle pulse when an instruction completes
//   Illegal_o         - sticky: unknown opcode decoded
//   Mem_Err_o         - sticky: memory handshake timed out
//   State_o           - current FSM state
//
// Control outputs are a Moore decode of the state register; only the fetch
// writes and the store retire are qualified by Mem_Ready_i in the same cycle.

module multicycle_control
   import multicycle_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] OP_i,
   input  logic       Mem_Ready_i,
   output logic       PC_Write_o,
   output logic       PC_Write_Cond_o,
   output logic [1:0] PC_Src_o,
   output logic       Old_PC_Write_o,
   output logic       IorD_o,
   output logic       Mem_Read_o,
   output logic       Mem_Write_o,
   output logic       IR_Write_o,
   output logic       Reg_Write_o,
   output logic [1:0] Wb_Src_o,
   output logic [1:0] ALU_Src_A_o,
   output logic [1:0] ALU_Src_B_o,
   output logic [2:0] ALU_Op_o,
   output logic       Retire_o,
   output logic       Illegal_o,
   output logic       Mem_Err_o,
   output logic [3:0] State_o
);

   state_t state;
   logic   illegal;
   logic   mem_err;
   logic   mem_active;
   logic   timeout;

   assign mem_active = is_mem_state(state);

   mc_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .CNT_W       (CNT_W)
   ) u_wait_timer (
      .clk     (clk),
      .reset   (reset),
      .active  (mem_active),
      .ready   (Mem_Ready_i),
      .timeout (timeout)
   );

   // ------------------------------------------------------------------
   // State register and sticky flags
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= S_FETCH;
         illegal <= 1'b0;
         mem_err <= 1'b0;
      end else begin
         case (state)
            S_FETCH: begin
               if (Mem_Ready_i) begin
                  state <= S_DECODE;
               end else if (timeout) begin
                  state   <= S_HALT;
                  mem_err <= 1'b1;
               end
            end
            S_DECODE: begin
               case (OP_i)
                  OP_R, OP_I, OP_LUI: state <= S_EXEC;
                  OP_B:               state <= S_BRANCH;
                  OP_LW, OP_SW:       state <= S_ADDR;
                  OP_JAL:             state <= S_JUMP;
                  OP_JALR:            state <= S_JALR_ADDR;
                  default: begin
                     // PC already advanced in FETCH, so the bad word is
                     // simply skipped.
                     state   <= S_FETCH;
                     illegal <= 1'b1;
                  end
               endcase
            end
            S_EXEC:      state <= S_WB_ALU;
            S_WB_ALU:    state <= S_FETCH;
            S_BRANCH:    state <= S_FETCH;
            S_ADDR:      state <= (OP_i == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
               if (Mem_Ready_i) begin
                  state <= S_WB_MEM;
               end else if (timeout) begin
                  state   <= S_HALT;
                  mem_err <= 1'b1;
               end
            end
            S_WB_MEM:    state <= S_FETCH;
            S_MEM_WR: begin
               if (Mem_Ready_i) begin
                  state <= S_FETCH;
               end else if (timeout) begin
                  state   <= S_HALT;
                  mem_err <= 1'b1;
               end
            end
            S_JALR_ADDR: state <= S_JUMP;
            S_JUMP:      state <= S_FETCH;
            S_HALT:      state <= S_HALT;
            default:     state <= S_FETCH;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Output decode
   // ------------------------------------------------------------------
   always_comb begin
      PC_Write_o      = 1'b0;
      PC_Write_Cond_o = 1'b0;
      PC_Src_o        = PC_SRC_ALU;
      Old_PC_Write_o  = 1'b0;
      IorD_o          = 1'b0;
      Mem_Read_o      = 1'b0;
      Mem_Write_o     = 1'b0;
      IR_Write_o      = 1'b0;
      Reg_Write_o     = 1'b0;
      Wb_Src_o        = WB_ALUOUT;
      ALU_Src_A_o     = SRCA_PC;
      ALU_Src_B_o     = SRCB_RS2;
      ALU_Op_o        = ALU_R;
      Retire_o        = 1'b0;

      case (state)
         S_FETCH: begin
            // PC + 4 goes straight into PC while the old PC is preserved
            // for the target computation in DECODE.
            Mem_Read_o     = 1'b1;
            IorD_o         = 1'b0;
            ALU_Src_A_o    = SRCA_PC;
            ALU_Src_B_o    = SRCB_FOUR;
            ALU_Op_o       = ALU_ADD;
            PC_Src_o       = PC_SRC_ALU;
            IR_Write_o     = Mem_Ready_i;
            PC_Write_o     = Mem_Ready_i;
            Old_PC_Write_o = Mem_Ready_i;
         end
         S_DECODE: begin
            // Speculative branch/jump target OldPC + imm into ALU_Out
            ALU_Src_A_o = SRCA_OLDPC;
            ALU_Src_B_o = SRCB_IMM;
            ALU_Op_o    = ALU_ADD;
         end
         S_EXEC: begin
            ALU_Src_A_o = SRCA_RS1;
            ALU_Src_B_o = (OP_i == OP_R) ? SRCB_RS2 : SRCB_IMM;
            case (OP_i)
               OP_I:    ALU_Op_o = ALU_I;
               OP_LUI:  ALU_Op_o = ALU_U;
               default: ALU_Op_o = ALU_R;
            endcase
         end
         S_WB_ALU: begin
            Reg_Write_o = 1'b1;
            Wb_Src_o    = WB_ALUOUT;
            Retire_o    = 1'b1;
         end
         S_BRANCH: begin
            // Compare in the ALU; target was latched in DECODE
            ALU_Src_A_o     = SRCA_RS1;
            ALU_Src_B_o     = SRCB_RS2;
            ALU_Op_o        = ALU_B;
            PC_Write_Cond_o = 1'b1;
            PC_Src_o        = PC_SRC_ALUOUT;
            Retire_o        = 1'b1;
         end
         S_ADDR: begin
            ALU_Src_A_o = SRCA_RS1;
            ALU_Src_B_o = SRCB_IMM;
            ALU_Op_o    = ALU_ADD;
         end
         S_MEM_RD: begin
            IorD_o     = 1'b1;
            Mem_Read_o = 1'b1;
         end
         S_WB_MEM: begin
            Reg_Write_o = 1'b1;
            Wb_Src_o    = WB_MDR;
            Retire_o    = 1'b1;
         end
         S_MEM_WR: begin
            IorD_o      = 1'b1;
            Mem_Write_o = 1'b1;
            Retire_o    = Mem_Ready_i;
         end
         S_JALR_ADDR: begin
            ALU_Src_A_o = SRCA_RS1;
            ALU_Src_B_o = SRCB_IMM;
            ALU_Op_o    = ALU_JALR;
         end
         S_JUMP: begin
            // PC still holds old PC + 4, which is the link value
            Reg_Write_o = 1'b1;
            Wb_Src_o    = WB_PC;
            PC_Write_o  = 1'b1;
            PC_Src_o    = PC_SRC_ALUOUT;
            Retire_o    = 1'b1;
         end
         default: begin
            // HALT and unused encodings drive no enables
         end
      endcase
   end

   assign Illegal_o = illegal;
   assign Mem_Err_o = mem_err;
   assign State_o   = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control with MEM_TIMEOUT = 4.
// The driver pushes one expected control word per cycle; a monitor on the
// falling edge pops and compares against the DUT outputs.

module tb_multicycle_control;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic [1:0] pc_src;
      logic       old_pc_write;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_write;
      logic [1:0] wb_src;
      logic [1:0] alu_a;
      logic [1:0] alu_b;
      logic [2:0] alu_op;
      logic       retire;
      logic       illegal;
      logic       mem_err;
      logic [3:0] state;
   } ctl_t;

   logic       clk;
   logic       reset;
   logic [6:0] OP_i;
   logic       Mem_Ready_i;
   logic       PC_Write_o, PC_Write_Cond_o, Old_PC_Write_o, IorD_o;
   logic       Mem_Read_o, Mem_Write_o, IR_Write_o, Reg_Write_o;
   logic [1:0] PC_Src_o, Wb_Src_o, ALU_Src_A_o, ALU_Src_B_o;
   logic [2:0] ALU_Op_o;
   logic       Retire_o, Illegal_o, Mem_Err_o;
   logic [3:0] State_o;

   multicycle_control #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
      .clk             (clk),
      .reset           (reset),
      .OP_i            (OP_i),
      .Mem_Ready_i     (Mem_Ready_i),
      .PC_Write_o      (PC_Write_o),
      .PC_Write_Cond_o (PC_Write_Cond_o),
      .PC_Src_o        (PC_Src_o),
      .Old_PC_Write_o  (Old_PC_Write_o),
      .IorD_o          (IorD_o),
      .Mem_Read_o      (Mem_Read_o),
      .Mem_Write_o     (Mem_Write_o),
      .IR_Write_o      (IR_Write_o),
      .Reg_Write_o     (Reg_Write_o),
      .Wb_Src_o        (Wb_Src_o),
      .ALU_Src_A_o     (ALU_Src_A_o),
      .ALU_Src_B_o     (ALU_Src_B_o),
      .ALU_Op_o        (ALU_Op_o),
      .Retire_o        (Retire_o),
      .Illegal_o       (Illegal_o),
      .Mem_Err_o       (Mem_Err_o),
      .State_o         (State_o)
   );

   ctl_t got;
   assign got = {PC_Write_o, PC_Write_Cond_o, PC_Src_o, Old_PC_Write_o, IorD_o,
                 Mem_Read_o, Mem_Write_o, IR_Write_o, Reg_Write_o, Wb_Src_o,
                 ALU_Src_A_o, ALU_Src_B_o, ALU_Op_o, Retire_o, Illegal_o,
                 Mem_Err_o, State_o};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   ctl_t  exp_q[$];
   string name_q[$];
   int    checks = 0;
   int    errors = 0;
   logic  exp_ill = 1'b0;
   logic  exp_err = 1'b0;

   // Expected control words, taken state by state from the output table
   function automatic ctl_t e_fetch(input logic rdy);
      ctl_t e = '0;
      e.mem_read = 1'b1; e.alu_b = 2'b01; e.alu_op = 3'b100;
      e.ir_write = rdy; e.pc_write = rdy; e.old_pc_write = rdy;
      e.state = 4'd0;
      return e;
   endfunction
   function automatic ctl_t e_decode();
      ctl_t e = '0;
      e.alu_a = 2'b01; e.alu_b = 2'b10; e.alu_op = 3'b100; e.state = 4'd1;
      return e;
   endfunction
   function automatic ctl_t e_exec(input logic [1:0] b, input logic [2:0] aop);
      ctl_t e = '0;
      e.alu_a = 2'b10; e.alu_b = b; e.alu_op = aop; e.state = 4'd2;
      return e;
   endfunction
   function automatic ctl_t e_wb_alu();
      ctl_t e = '0;
      e.reg_write = 1'b1; e.retire = 1'b1; e.state = 4'd3;
      return e;
   endfunction
   function automatic ctl_t e_branch();
      ctl_t e = '0;
      e.alu_a = 2'b10; e.alu_op = 3'b011; e.pc_write_cond = 1'b1;
      e.pc_src = 2'b01; e.retire = 1'b1; e.state = 4'd4;
      return e;
   endfunction
   function automatic ctl_t e_addr();
      ctl_t e = '0;
      e.alu_a = 2'b10; e.alu_b = 2'b10; e.alu_op = 3'b100; e.state = 4'd5;
      return e;
   endfunction
   function automatic ctl_t e_mem_rd();
      ctl_t e = '0;
      e.iord = 1'b1; e.mem_read = 1'b1; e.state = 4'd6;
      return e;
   endfunction
   function automatic ctl_t e_wb_mem();
      ctl_t e = '0;
      e.reg_write = 1'b1; e.wb_src = 2'b01; e.retire = 1'b1; e.state = 4'd7;
      return e;
   endfunction
   function automatic ctl_t e_mem_wr(input logic rdy);
      ctl_t e = '0;
      e.iord = 1'b1; e.mem_write = 1'b1; e.retire = rdy; e.state = 4'd8;
      return e;
   endfunction
   function automatic ctl_t e_jalr();
      ctl_t e = '0;
      e.alu_a = 2'b10; e.alu_b = 2'b10; e.alu_op = 3'b111; e.state = 4'd9;
      return e;
   endfunction
   function automatic ctl_t e_jump();
      ctl_t e = '0;
      e.reg_write = 1'b1; e.wb_src = 2'b10; e.pc_write = 1'b1;
      e.pc_src = 2'b01; e.retire = 1'b1; e.state = 4'd10;
      return e;
   endfunction
   function automatic ctl_t e_halt();
      ctl_t e = '0;
      e.state = 4'd12;
      return e;
   endfunction

   // One clock cycle: drive inputs after the edge, queue what the DUT
   // must show during this cycle.
   task automatic step(input logic rst_v, input logic [6:0] op, input logic rdy,
                       input ctl_t e, input string name);
      ctl_t ee;
      @(posedge clk);
      #1;
      reset       = rst_v;
      OP_i        = op;
      Mem_Ready_i = rdy;
      ee          = e;
      ee.illegal  = exp_ill;
      ee.mem_err  = exp_err;
      exp_q.push_back(ee);
      name_q.push_back(name);
   endtask

   // Monitor
   initial begin
      ctl_t  e;
      string n;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (got !== e) begin
               errors++;
               $display("FAIL %s: got=%h required=%h (state got %0d req %0d)",
                        n, got, e, got.state, e.state);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; OP_i = 7'h00; Mem_Ready_i = 1'b0;

      // Reset for two edges, then R-type with no waits
      step(1'b0, 7'h00, 1'b0, e_fetch(1'b0), "reset_1");
      step(1'b1, 7'h33, 1'b1, e_fetch(1'b1), "r_fetch");
      step(1'b1, 7'h33, 1'b1, e_decode(), "r_decode");
      step(1'b1, 7'h33, 1'b1, e_exec(2'b00, 3'b000), "r_exec");
      step(1'b1, 7'h33, 1'b1, e_wb_alu(), "r_wb_retire");

      // LW with three wait cycles in MEM_RD
      step(1'b1, 7'h03, 1'b1, e_fetch(1'b1), "lw_fetch");
      step(1'b1, 7'h03, 1'b1, e_decode(), "lw_decode");
      step(1'b1, 7'h03, 1'b1, e_addr(), "lw_addr");
      for (int i = 0; i < 3; i++)
         step(1'b1, 7'h03, 1'b0, e_mem_rd(), "lw_mem_rd_wait");
      step(1'b1, 7'h03, 1'b1, e_mem_rd(), "lw_mem_rd_ready");
      step(1'b1, 7'h03, 1'b1, e_wb_mem(), "lw_wb_mem_retire");

      // JALR
      step(1'b1, 7'h67, 1'b1, e_fetch(1'b1), "jalr_fetch");
      step(1'b1, 7'h67, 1'b1, e_decode(), "jalr_decode");
      step(1'b1, 7'h67, 1'b1, e_jalr(), "jalr_addr");
      step(1'b1, 7'h67, 1'b1, e_jump(), "jalr_jump");

      // SW: four waits, ready exactly when the count equals the limit
      step(1'b1, 7'h23, 1'b1, e_fetch(1'b1), "sw_fetch");
      step(1'b1, 7'h23, 1'b1, e_decode(), "sw_decode");
      step(1'b1, 7'h23, 1'b1, e_addr(), "sw_addr");
      for (int i = 0; i < 4; i++)
         step(1'b1, 7'h23, 1'b0, e_mem_wr(1'b0), "sw_mem_wr_wait");
      step(1'b1, 7'h23, 1'b1, e_mem_wr(1'b1), "sw_ready_at_limit");

      // Branch, JAL, I-type, LUI
      step(1'b1, 7'h63, 1'b1, e_fetch(1'b1), "b_fetch");
      step(1'b1, 7'h63, 1'b1, e_decode(), "b_decode");
      step(1'b1, 7'h63, 1'b1, e_branch(), "b_branch");
      step(1'b1, 7'h6F, 1'b1, e_fetch(1'b1), "jal_fetch");
      step(1'b1, 7'h6F, 1'b1, e_decode(), "jal_decode");
      step(1'b1, 7'h6F, 1'b1, e_jump(), "jal_jump");
      step(1'b1, 7'h13, 1'b1, e_fetch(1'b1), "i_fetch");
      step(1'b1, 7'h13, 1'b1, e_decode(), "i_decode");
      step(1'b1, 7'h13, 1'b1, e_exec(2'b10, 3'b001), "i_exec");
      step(1'b1, 7'h13, 1'b1, e_wb_alu(), "i_wb");
      step(1'b1, 7'h37, 1'b1, e_fetch(1'b1), "lui_fetch");
      step(1'b1, 7'h37, 1'b1, e_decode(), "lui_decode");
      step(1'b1, 7'h37, 1'b1, e_exec(2'b10, 3'b010), "lui_exec");
      step(1'b1, 7'h37, 1'b1, e_wb_alu(), "lui_wb");

      // Illegal opcode after one fetch wait; flag stays through later work
      step(1'b1, 7'h7F, 1'b0, e_fetch(1'b0), "ill_fetch_wait");
      step(1'b1, 7'h7F, 1'b1, e_fetch(1'b1), "ill_fetch");
      step(1'b1, 7'h7F, 1'b1, e_decode(), "ill_decode_no_retire");
      exp_ill = 1'b1;
      step(1'b1, 7'h33, 1'b1, e_fetch(1'b1), "ill_back_to_fetch");
      step(1'b1, 7'h33, 1'b1, e_decode(), "ill_r_decode");
      step(1'b1, 7'h33, 1'b1, e_exec(2'b00, 3'b000), "ill_r_exec");
      step(1'b1, 7'h33, 1'b1, e_wb_alu(), "ill_r_wb");

      // Reset during a store wait abandons the access and clears flags
      step(1'b1, 7'h23, 1'b1, e_fetch(1'b1), "rs_fetch");
      step(1'b1, 7'h23, 1'b1, e_decode(), "rs_decode");
      step(1'b1, 7'h23, 1'b1, e_addr(), "rs_addr");
      step(1'b1, 7'h23, 1'b0, e_mem_wr(1'b0), "rs_mem_wr_wait");
      step(1'b0, 7'h23, 1'b0, e_mem_wr(1'b0), "rs_reset_in_mem_wr");
      exp_ill = 1'b0;

      // Fetch timeout: four tolerated waits, fifth without ready -> HALT
      step(1'b1, 7'h33, 1'b0, e_fetch(1'b0), "rs_after_reset_fetch");
      for (int i = 0; i < 4; i++)
         step(1'b1, 7'h33, 1'b0, e_fetch(1'b0), "to_fetch_wait");
      exp_err = 1'b1;
      for (int i = 0; i < 3; i++)
         step(1'b1, 7'h33, 1'b1, e_halt(), "to_halt_sticky");
      step(1'b0, 7'h33, 1'b1, e_halt(), "to_halt_reset_low");
      exp_err = 1'b0;
      step(1'b1, 7'h33, 1'b0, e_fetch(1'b0), "to_after_reset");

      @(posedge clk);
      @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain: entries left=%0d required=0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Sequencing FSM for the multi-cycle RISC-V core. The single-cycle decoder is replaced by a state machine that steps the shared datapath through fetch, decode, execute, memory and writeback. It supports the same instruction set: R-type, I-logic, LUI, B-type, LW, SW, JAL and JALR. Instruction and data accesses share one memory port, and every access waits on a ready handshake.

Parameters:
MEM_TIMEOUT, 255, maximum number of wait cycles allowed for Mem_Ready_i during any single memory access.
CNT_W, 8, width of the wait counter. Must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
clk  in  1  rising-edge clock
reset  in  1  active-low, synchronous reset
OP_i  in  7  opcode field of the instruction register
Mem_Ready_i  in  1  memory has completed the current read or write this cycle
PC_Write_o  out  1  unconditional PC load
PC_Write_Cond_o  out  1  PC load qualified by the datapath branch-taken flag
PC_Src_o  out  2  PC source: 00 = ALU result, 01 = ALU_Out register
Old_PC_Write_o  out  1  capture current PC into the OldPC register
IorD_o  out  1  memory address select: 0 = PC, 1 = ALU_Out
Mem_Read_o  out  1  memory read request
Mem_Write_o  out  1  memory write request
IR_Write_o  out  1  load instruction register
Reg_Write_o  out  1  register-file write enable
Wb_Src_o  out  2  writeback source: 00 = ALU_Out, 01 = MDR, 10 = PC
ALU_Src_A_o  out  2  ALU A input: 00 = PC, 01 = OldPC, 10 = rs1
ALU_Src_B_o  out  2  ALU B input: 00 = rs2, 01 = constant 4, 10 = immediate
ALU_Op_o  out  3  ALU operation: 000 R, 001 I, 010 U, 011 B, 100 add, 101 S, 110 J, 111 JALR
Retire_o  out  1  one-cycle pulse when an instruction completes
Illegal_o  out  1  sticky flag: unknown opcode was decoded
Mem_Err_o  out  1  sticky flag: memory handshake timed out
State_o  out  4  current state, for debug

Behaviour:
- Outputs are Moore-style: each is a combinational decode of the state register, except the fetch/memory writes, which are gated by Mem_Ready_i as noted below. Any control output not listed for a state is 0.
- Reset (reset == 0 at a clock edge): state goes to FETCH, wait counter is cleared, Illegal_o and Mem_Err_o are cleared. All outputs take their FETCH values. Reset mid-access abandons the access with no PC or IR write.
- FETCH:
  - Mem_Read_o = 1, IorD_o = 0, ALU_Src_A_o = 00, ALU_Src_B_o = 01, ALU_Op_o = 100, PC_Src_o = 00.
  - IR_Write_o, PC_Write_o and Old_PC_Write_o equal Mem_Ready_i.
  - Leaves to DECODE on Mem_Ready_i; otherwise stays.
- DECODE:
  - Computes the branch/jump target: ALU_Src_A_o = 01, ALU_Src_B_o = 10, ALU_Op_o = 100; result latched into ALU_Out by the datapath.
  - Next state by OP_i: 0x33/0x13/0x37 -> EXEC; 0x63 -> BRANCH; 0x03/0x23 -> ADDR; 0x6F -> JUMP; 0x67 -> JALR_ADDR.
  - Any other opcode: set Illegal_o, pulse Retire_o = 0, return to FETCH. The PC has already advanced, so the instruction is skipped.
- EXEC:
  - ALU_Src_A_o = 10. ALU_Src_B_o = 00 for R-type, 10 otherwise.
  - ALU_Op_o = 000 / 001 / 010 per opcode. Next state: WB_ALU.
- WB_ALU: Reg_Write_o = 1, Wb_Src_o = 00, Retire_o = 1. Next: FETCH.
- BRANCH:
  - ALU_Src_A_o = 10, ALU_Src_B_o = 00, ALU_Op_o = 011.
  - PC_Write_Cond_o = 1, PC_Src_o = 01, Retire_o = 1. Next: FETCH.
- ADDR: ALU_Src_A_o = 10, ALU_Src_B_o = 10, ALU_Op_o = 100. Next: MEM_RD for LW, MEM_WR for SW.
- MEM_RD: IorD_o = 1, Mem_Read_o = 1. Waits for Mem_Ready_i, then -> WB_MEM.
- WB_MEM: Reg_Write_o = 1, Wb_Src_o = 01, Retire_o = 1. Next: FETCH.
- MEM_WR: IorD_o = 1, Mem_Write_o = 1. On Mem_Ready_i: Retire_o = 1 and -> FETCH.
- JALR_ADDR: ALU_Src_A_o = 10, ALU_Src_B_o = 10, ALU_Op_o = 111. Next: JUMP.
- JUMP: Reg_Write_o = 1, Wb_Src_o = 10 (PC already holds old PC + 4), PC_Write_o = 1, PC_Src_o = 01, Retire_o = 1. Next: FETCH.
- Latency with zero wait states (cycles from entering FETCH to retire): R/I/U = 4, LW = 5, SW = 4, B = 3, JAL = 3, JALR = 4. Each wait cycle adds 1.
- Wait counter:
  - Increments each cycle spent in FETCH, MEM_RD or MEM_WR with Mem_Ready_i = 0.
  - Clears on any state change.
  - When it reaches MEM_TIMEOUT with no ready: set Mem_Err_o, enter HALT.
  - Mem_Ready_i arriving on the same cycle the count reaches MEM_TIMEOUT counts as success.
- HALT: all enables 0. Exit only via reset.
- Mem_Ready_i is ignored in all states other than FETCH, MEM_RD and MEM_WR.

Decomposition:
- Shared package multicycle_pkg holds:
  - opcode localparams (0x33, 0x13, 0x37, 0x63, 0x03, 0x23, 0x6F, 0x67);
  - the 4-bit state encoding (FETCH = 0 ... HALT = 12);
  - ALU_Op codes;
  - mux-select codes for PC_Src, Wb_Src, ALU_Src_A and ALU_Src_B.
- One sub-module, mc_wait_timer: the wait counter plus timeout compare. Everything else stays in a single FSM module.

Test Plan:
- Reset low for 2 cycles, then release, Mem_Ready_i = 1, OP_i = 0x33 -> states FETCH, DECODE, EXEC, WB_ALU; Retire_o pulses at cycle 4; Reg_Write_o high only in WB_ALU.
- OP_i = 0x03, Mem_Ready_i low for 3 cycles in MEM_RD -> MEM_RD held 4 cycles, Wb_Src_o = 01 in WB_MEM, retire at cycle 8.
- OP_i = 0x67 -> sequence DECODE, JALR_ADDR (ALU_Op_o = 111), JUMP with PC_Write_o = 1, Wb_Src_o = 10.
- OP_i = 0x7F -> Illegal_o set after DECODE, returns to FETCH, no Reg_Write_o and no Retire_o. Illegal_o stays set until reset.
- Mem_Ready_i held low in FETCH, MEM_TIMEOUT = 4 -> Mem_Err_o = 1 and State_o = HALT after 4 wait cycles; stays there until reset, with no writes.
- Reset asserted during MEM_WR wait -> next state FETCH, Mem_Write_o = 0, flags cleared.
